// File: rtl/descriptor_memory_dp_if.sv
// Avalon-MM slave bundle for one descriptor RAM port.
// Carries parity_err when DESCRIPTOR_MEMORY_PARITY_EN is defined.
interface descriptor_memory_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
  logic                    parity_err;
`endif

  modport master (
    output address, chipselect, read, write,
    output byteenable, writedata,
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
    input  parity_err,
`endif
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, chipselect, read, write,
    input  byteenable, writedata,
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
    output parity_err,
`endif
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/descriptor_memory_dp.sv
// True-dual-port descriptor RAM, two Avalon-MM slaves, 1 or 2 read latency.
// DESCRIPTOR_MEMORY_PARITY_EN adds per-byte even parity and error outputs.
module descriptor_memory_dp #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int DEPTH        = 2048,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "descriptor_memory.hex"
) (
  input  logic clk,
  input  logic reset,
  input  logic clken,
  input  logic reset_req,
  descriptor_memory_dp_if.slave s1,
  descriptor_memory_dp_if.slave s2
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
  ,
  output logic parity_err_sticky
`endif
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH + 1)'(DEPTH);

  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % 8 != 0 || DEPTH > 2 ** ADDR_WIDTH)
  begin : g_bad_geometry
    $error("bad DATA_WIDTH/DEPTH/ADDR_WIDTH");
  end

  logic                         en;
  logic [1:0]                   rd;
  logic [1:0]                   wr;
  logic [1:0]                   inr;
  logic [1:0][ADDR_WIDTH-1:0]   addr;
  logic [1:0][NB-1:0]           be;
  logic [1:0][DATA_WIDTH-1:0]   wd;

  assign en   = clken & ~reset_req;
  assign addr = {s2.address, s1.address};
  assign be   = {s2.byteenable, s1.byteenable};
  assign wd   = {s2.writedata, s1.writedata};

  // Write has priority over a simultaneous read on the same port.
  assign wr[0] = s1.chipselect & s1.write & en;
  assign wr[1] = s2.chipselect & s2.write & en;
  assign rd[0] = s1.chipselect & s1.read & ~s1.write & en;
  assign rd[1] = s2.chipselect & s2.read & ~s2.write & en;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      inr[p] = {1'b0, addr[p]} < DEPTH_W;
    end
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
  logic [NB-1:0]         pmem [DEPTH];
`endif

  // s2 first, s1 last: s1 overrides lanes both ports enable.
  always_ff @(posedge clk) begin
    for (int p = 1; p >= 0; p--) begin
      if (wr[p] && inr[p]) begin
        for (int b = 0; b < NB; b++) begin
          if (be[p][b]) begin
            mem[addr[p]][8*b +: 8] <= wd[p][8*b +: 8];
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
            pmem[addr[p]][b] <= ^wd[p][8*b +: 8];
`endif
          end
        end
      end
    end
  end

  logic [1:0]                 v1;
  logic [1:0][DATA_WIDTH-1:0] d1;
  logic [1:0]                 vq;
  logic [1:0][DATA_WIDTH-1:0] dq;
  logic [1:0]                 vo;
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
  logic [1:0][NB-1:0]         p1;
  logic [1:0][NB-1:0]         pq;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= '0;
      d1 <= '0;
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
      p1 <= '0;
`endif
    end else if (en) begin
      v1 <= rd;
      for (int p = 0; p < 2; p++) begin
        if (rd[p]) begin
          d1[p] <= inr[p] ? mem[addr[p]] : '0;
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
          p1[p] <= inr[p] ? pmem[addr[p]] : '0;
`endif
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_out_reg
    logic [1:0]                 v2;
    logic [1:0][DATA_WIDTH-1:0] d2;
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
    logic [1:0][NB-1:0]         p2;
`endif
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v2 <= '0;
        d2 <= '0;
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
        p2 <= '0;
`endif
      end else if (en) begin
        v2 <= v1;
        d2 <= d1;
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
        p2 <= p1;
`endif
      end
    end
    assign vq = v2;
    assign dq = d2;
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
    assign pq = p2;
`endif
  end else begin : g_ram_out
    assign vq = v1;
    assign dq = d1;
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
    assign pq = p1;
`endif
  end

  // Held entries stay invisible until the enable returns.
  assign vo = vq & {2{en}};

  assign s1.waitrequest   = ~en;
  assign s1.readdata      = dq[0];
  assign s1.readdatavalid = vo[0];
  assign s2.waitrequest   = ~en;
  assign s2.readdata      = dq[1];
  assign s2.readdatavalid = vo[1];

`ifdef DESCRIPTOR_MEMORY_PARITY_EN
  logic [1:0] perr;

  always_comb begin
    perr = '0;
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < NB; b++) begin
        perr[p] = perr[p]
          | (vo[p] & (pq[p][b] ^ (^dq[p][8*b +: 8])));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err_sticky <= 1'b0;
    end else if (|perr) begin
      parity_err_sticky <= 1'b1;
    end
  end

  assign s1.parity_err = perr[0];
  assign s2.parity_err = perr[1];
`endif
endmodule

// File: tb/tb_descriptor_memory_dp.sv
// Bench for descriptor_memory_dp: two DUTs (latency 1 and 2) share stimulus
// and are checked every cycle against a word-array/queue reference model.
module tb_descriptor_memory_dp;
  localparam int DW    = 32;
  localparam int AW    = 11;
  localparam int DEPTH = 2000;
  localparam int NB    = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic clken;
  logic reset_req;
  always #5 clk = ~clk;

  logic          cs [2];
  logic          rd [2];
  logic          wr [2];
  logic [AW-1:0] addr [2];
  logic [NB-1:0] be [2];
  logic [DW-1:0] wd [2];

  descriptor_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a1 ();
  descriptor_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a2 ();
  descriptor_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
  descriptor_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b2 ();

  assign a1.address = addr[0]; assign a1.chipselect = cs[0];
  assign a1.read = rd[0]; assign a1.write = wr[0];
  assign a1.byteenable = be[0]; assign a1.writedata = wd[0];
  assign b1.address = addr[0]; assign b1.chipselect = cs[0];
  assign b1.read = rd[0]; assign b1.write = wr[0];
  assign b1.byteenable = be[0]; assign b1.writedata = wd[0];
  assign a2.address = addr[1]; assign a2.chipselect = cs[1];
  assign a2.read = rd[1]; assign a2.write = wr[1];
  assign a2.byteenable = be[1]; assign a2.writedata = wd[1];
  assign b2.address = addr[1]; assign b2.chipselect = cs[1];
  assign b2.read = rd[1]; assign b2.write = wr[1];
  assign b2.byteenable = be[1]; assign b2.writedata = wd[1];

  logic          ov [2][2];
  logic          ow [2][2];
  logic [DW-1:0] od [2][2];
  assign ov[0][0] = a1.readdatavalid; assign ow[0][0] = a1.waitrequest;
  assign ov[0][1] = a2.readdatavalid; assign ow[0][1] = a2.waitrequest;
  assign ov[1][0] = b1.readdatavalid; assign ow[1][0] = b1.waitrequest;
  assign ov[1][1] = b2.readdatavalid; assign ow[1][1] = b2.waitrequest;
  assign od[0][0] = a1.readdata; assign od[0][1] = a2.readdata;
  assign od[1][0] = b1.readdata; assign od[1][1] = b2.readdata;
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
  logic ope [2][2];
  logic ost [2];
  assign ope[0][0] = a1.parity_err; assign ope[0][1] = a2.parity_err;
  assign ope[1][0] = b1.parity_err; assign ope[1][1] = b2.parity_err;
`endif

  descriptor_memory_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .READ_LATENCY(1), .INIT_FILE("descriptor_memory.hex")
  ) u_d1 (
    .clk(clk), .reset(rst), .clken(clken), .reset_req(reset_req),
    .s1(a1), .s2(a2)
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
    , .parity_err_sticky(ost[0])
`endif
  );

  descriptor_memory_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .READ_LATENCY(2), .INIT_FILE("descriptor_memory.hex")
  ) u_d2 (
    .clk(clk), .reset(rst), .clken(clken), .reset_req(reset_req),
    .s1(b1), .s2(b2)
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
    , .parity_err_sticky(ost[1])
`endif
  );

  // Reference: word array plus per-(latency,port) queue of pending reads,
  // each aged by enabled edges; visible when age == latency-1.
  typedef struct {
    logic [DW-1:0] data;
    int            age;
    bit            perr;
  } ent_t;

  logic [DW-1:0] m [DEPTH];
  bit            bad [DEPTH];
  ent_t          q [2][2][$];
  int            errors = 0;
  int            checks = 0;
  bit            rec = 0;
  logic [DW-1:0] cap [$];

  task automatic chk(string nm, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit inr(logic [AW-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  task automatic model_edge();
    bit            acc [2];
    bit            pe [2];
    logic [DW-1:0] rv [2];
    ent_t          nq [$];
    ent_t          e;
    if (rst) begin
      for (int l = 0; l < 2; l++)
        for (int p = 0; p < 2; p++) q[l][p].delete();
      return;
    end
    if (!clken || reset_req) return;
    for (int p = 0; p < 2; p++) begin
      acc[p] = cs[p] && rd[p] && !wr[p];
      rv[p]  = inr(addr[p]) ? m[addr[p]] : '0;
      pe[p]  = inr(addr[p]) && bad[addr[p]];
    end
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 2; p++) begin
        nq = {};
        for (int i = 0; i < q[l][p].size(); i++) begin
          e = q[l][p][i];
          e.age++;
          if (e.age <= l) nq.push_back(e);
        end
        if (acc[p]) nq.push_back('{rv[p], 0, pe[p]});
        q[l][p] = nq;
      end
    end
    for (int p = 1; p >= 0; p--) begin
      if (cs[p] && wr[p] && inr(addr[p])) begin
        for (int b = 0; b < NB; b++)
          if (be[p][b]) m[addr[p]][8*b +: 8] = wd[p][8*b +: 8];
        bad[addr[p]] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    bit            e;
    bit            ev;
    bit            ep;
    logic [DW-1:0] ed;
    e = clken && !reset_req;
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 2; p++) begin
        ev = 0; ep = 0; ed = '0;
        for (int i = 0; i < q[l][p].size(); i++) begin
          if (q[l][p][i].age == l) begin
            ev = 1;
            ed = q[l][p][i].data;
            ep = q[l][p][i].perr;
          end
        end
        ev = ev && e && !rst;
        chk($sformatf("waitreq_rl%0d_s%0d", l+1, p+1), ow[l][p], !e);
        chk($sformatf("valid_rl%0d_s%0d", l+1, p+1), ov[l][p], ev);
        if (ev) chk($sformatf("data_rl%0d_s%0d", l+1, p+1), od[l][p], ed);
        if (rst) chk($sformatf("rstdata_rl%0d_s%0d", l+1, p+1), od[l][p], '0);
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
        chk($sformatf("perr_rl%0d_s%0d", l+1, p+1), ope[l][p], ev && ep);
`endif
      end
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
      if (rst) chk($sformatf("sticky_rst_rl%0d", l+1), ost[l], 1'b0);
`endif
    end
    if (rec && ov[0][0]) cap.push_back(od[0][0]);
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      cs[p] = 0; rd[p] = 0; wr[p] = 0;
    end
  endtask

  task automatic wr1(int p, logic [AW-1:0] a, logic [DW-1:0] d,
                     logic [NB-1:0] b);
    idle();
    cs[p] = 1; wr[p] = 1; addr[p] = a; wd[p] = d; be[p] = b;
    step();
    idle();
  endtask

  task automatic read_lat(int p, logic [AW-1:0] a, logic [DW-1:0] expd,
                          string nm);
    int            lat [2];
    logic [DW-1:0] got [2];
    lat = '{0, 0};
    got = '{'0, '0};
    idle();
    cs[p] = 1; rd[p] = 1; addr[p] = a;
    step();
    idle();
    for (int n = 1; n <= 6; n++) begin
      for (int l = 0; l < 2; l++) begin
        if (lat[l] == 0 && ov[l][p]) begin
          lat[l] = n;
          got[l] = od[l][p];
        end
      end
      step();
    end
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("%s_lat_rl%0d", nm, l+1), lat[l], l + 1);
      chk($sformatf("%s_data_rl%0d", nm, l+1), got[l], expd);
    end
  endtask

  function automatic logic [AW-1:0] pick();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return AW'(r);
    return AW'(1996 + (r - 12) * 7);
  endfunction

  initial begin
    rst = 1; clken = 1; reset_req = 0;
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0; be[p] = '0; wd[p] = '0;
    end
    idle();
    step();
    step();
    rst = 0;
    step();

    for (int a = 0; a < 12; a++) wr1(a % 2, AW'(a), $urandom, 4'hf);
    wr1(1, AW'(1996), $urandom, 4'hf);

    wr1(0, AW'(5), 32'hDEADBEEF, 4'b1111);
    read_lat(1, AW'(5), 32'hDEADBEEF, "s1w_s2r");

    wr1(0, AW'(3), 32'h11223344, 4'b1111);
    wr1(0, AW'(3), 32'hAABBCCDD, 4'b0101);
    chk("model_merge", m[3], 32'h11BB33DD);
    read_lat(0, AW'(3), 32'h11BB33DD, "merge");

    idle();
    cs[0] = 1; wr[0] = 1; addr[0] = AW'(7); wd[0] = 32'hFFFF0000;
    be[0] = 4'b1100;
    cs[1] = 1; wr[1] = 1; addr[1] = AW'(7); wd[1] = 32'h0000ABCD;
    be[1] = 4'b1111;
    step();
    idle();
    read_lat(1, AW'(7), 32'hFFFFABCD, "dualwr");

    rec = 1;
    cap.delete();
    idle();
    cs[0] = 1; rd[0] = 1; addr[0] = AW'(5);
    step();
    addr[0] = AW'(3);
    step();
    clken = 0; addr[0] = AW'(7);
    step();
    step();
    clken = 1;
    step();
    idle();
    repeat (4) step();
    rec = 0;
    chk("b2b_count", cap.size(), 3);
    if (cap.size() == 3) begin
      chk("b2b_0", cap[0], 32'hDEADBEEF);
      chk("b2b_1", cap[1], 32'h11BB33DD);
      chk("b2b_2", cap[2], 32'hFFFFABCD);
    end

    idle();
    cs[0] = 1; rd[0] = 1; addr[0] = AW'(5);
    step();
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
    repeat (4) step();
    read_lat(0, AW'(5), 32'hDEADBEEF, "after_rst");

    wr1(0, AW'(2010), 32'h12345678, 4'hf);
    read_lat(1, AW'(2010), 32'h0, "oor");

    idle();
    cs[0] = 1; wr[0] = 1; addr[0] = AW'(5); wd[0] = 32'h01020304;
    be[0] = 4'hf;
    cs[1] = 1; rd[1] = 1; addr[1] = AW'(5);
    step();
    idle();
    repeat (3) step();
    read_lat(1, AW'(5), 32'h01020304, "rdw_new");

    for (int i = 0; i < 300; i++) begin
      clken     = ($urandom_range(0, 9) != 0);
      reset_req = ($urandom_range(0, 19) == 0);
      for (int p = 0; p < 2; p++) begin
        cs[p]   = ($urandom_range(0, 3) != 0);
        rd[p]   = $urandom_range(0, 1) == 1;
        wr[p]   = ($urandom_range(0, 2) == 0);
        addr[p] = pick();
        be[p]   = NB'($urandom);
        wd[p]   = $urandom;
      end
      step();
    end
    clken = 1; reset_req = 0;
    idle();
    repeat (3) step();

`ifdef DESCRIPTOR_MEMORY_PARITY_EN
    wr1(0, AW'(9), 32'hCAFEF00D, 4'hf);
    u_d1.mem[9][0] = ~u_d1.mem[9][0];
    u_d2.mem[9][0] = ~u_d2.mem[9][0];
    m[9][0] = ~m[9][0];
    bad[9] = 1;
    read_lat(0, AW'(9), 32'hCAFEF00C, "flip");
    step();
    chk("sticky_rl1", ost[0], 1'b1);
    chk("sticky_rl2", ost[1], 1'b1);
    wr1(0, AW'(9), 32'h0, 4'hf);
    step();
`endif

    rst = 1;
    step();
    rst = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
